// File: rtl/hdmi_frame_addr_gen_if.sv
// Read-command channel between the frame address generator and the DRAM read engine.
interface hdmi_frame_addr_gen_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0]       cmd_len;
  logic              cmd_done;

  modport master (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/hdmi_frame_addr_gen.sv
// Per-line burst read-command generator for HDMI scan-out: walks a frame buffer line by line,
// splitting each line into bursts of at most BURST_WORDS pixels with an outstanding-command limit.
module hdmi_frame_addr_gen #(
  parameter int unsigned X_SIZE          = 256,
  parameter int unsigned Y_SIZE          = 256,
  parameter int unsigned BURST_WORDS     = 64,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned LINE_STRIDE     = 1024,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic [ADDR_W-1:0]     fb_base,
  hdmi_frame_addr_gen_if.master cmd,
  output logic                  active,
  output logic                  frame_done,
  output logic                  line_overrun,
  output logic [3:0]            outstanding
);

  localparam int unsigned XW = $clog2(X_SIZE + 1);
  localparam int unsigned YW = $clog2(Y_SIZE + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LINE, S_ISSUE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] line_addr, line_addr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [XW-1:0]     x, x_d;
  logic [YW-1:0]     y, y_d;
  logic              resync, resync_d;
  logic              active_d, frame_done_d, overrun_d, valid_d;
  logic [15:0]       len_d;
  logic [3:0]        out_d;
  logic              acc, restart, last_burst;
  logic [31:0]       rem;

  // State and registered outputs
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state         <= S_IDLE;
      line_addr     <= '0;
      x             <= '0;
      y             <= '0;
      resync        <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_addr  <= '0;
      cmd.cmd_len   <= '0;
      active        <= 1'b0;
      frame_done    <= 1'b0;
      line_overrun  <= 1'b0;
      outstanding   <= '0;
    end else begin
      state         <= state_d;
      line_addr     <= line_addr_d;
      x             <= x_d;
      y             <= y_d;
      resync        <= resync_d;
      cmd.cmd_valid <= valid_d;
      cmd.cmd_addr  <= addr_d;
      cmd.cmd_len   <= len_d;
      active        <= active_d;
      frame_done    <= frame_done_d;
      line_overrun  <= overrun_d;
      outstanding   <= out_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    line_addr_d  = line_addr;
    addr_d       = cmd.cmd_addr;
    x_d          = x;
    y_d          = y;
    resync_d     = resync;
    active_d     = active;
    frame_done_d = 1'b0;
    overrun_d    = line_overrun;
    out_d        = outstanding;
    rem          = '0;

    acc        = cmd.cmd_valid && cmd.cmd_ready;
    last_burst = (32'(x) + 32'(cmd.cmd_len)) == 32'(X_SIZE);
    // A frame start can take effect at once unless a command is mid-handshake
    restart    = frame_start && !cmd.cmd_valid;

    if (acc && !cmd.cmd_done) begin
      out_d = outstanding + 4'd1;
    end else if (!acc && cmd.cmd_done && (outstanding != 4'd0)) begin
      out_d = outstanding - 4'd1;
    end

    if (restart) begin
      line_addr_d = fb_base;
      y_d         = '0;
      overrun_d   = 1'b0;
      active_d    = 1'b1;
      resync_d    = 1'b0;
      state_d     = S_WAIT_LINE;
    end else begin
      case (state)
        S_WAIT_LINE: begin
          if (line_start) begin
            x_d     = '0;
            addr_d  = line_addr;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (line_start) begin
            overrun_d = 1'b1;
          end
          // Pending command: latch the new base now, restart once it is accepted
          if (frame_start) begin
            resync_d    = 1'b1;
            line_addr_d = fb_base;
          end
          if (acc) begin
            x_d    = x + XW'(cmd.cmd_len);
            addr_d = cmd.cmd_addr + ADDR_W'(32'(cmd.cmd_len) * BYTES_PER_PIXEL);
            if (resync_d) begin
              y_d       = '0;
              overrun_d = 1'b0;
              active_d  = 1'b1;
              resync_d  = 1'b0;
              state_d   = S_WAIT_LINE;
            end else if (last_burst) begin
              line_addr_d = line_addr + ADDR_W'(LINE_STRIDE);
              y_d         = y + YW'(1);
              if (y == YW'(Y_SIZE - 1)) begin
                active_d     = 1'b0;
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
              end else begin
                state_d = S_WAIT_LINE;
              end
            end
          end
        end
        default: ;
      endcase
    end

    valid_d = (state_d == S_ISSUE) && (out_d < 4'(MAX_OUTSTANDING));

    if (state_d == S_ISSUE) begin
      rem   = 32'(X_SIZE) - 32'(x_d);
      len_d = (rem > 32'(BURST_WORDS)) ? 16'(BURST_WORDS) : 16'(rem);
    end else begin
      len_d = '0;
    end
  end

endmodule

// File: tb/tb_hdmi_frame_addr_gen.sv
// Scoreboard bench for hdmi_frame_addr_gen: a default-parameter instance and a short-line,
// two-outstanding instance, with expected commands queued by stimulus and checked by monitors.
module tb_hdmi_frame_addr_gen;

  logic clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  logic        rst = 1'b1;
  logic        fs_a = 1'b0, ls_a = 1'b0, fs_b = 1'b0, ls_b = 1'b0;
  logic [31:0] fb_a = '0, fb_b = '0;
  logic        rdy_a = 1'b0, rdy_b = 1'b0, auto_a = 1'b1, auto_b = 1'b1;
  logic        done_a = 1'b0, done_b = 1'b0;
  logic        acc_a1 = 1'b0, acc_a2 = 1'b0, acc_b1 = 1'b0, acc_b2 = 1'b0;
  logic        active_a, fd_a, ovr_a, active_b, fd_b, ovr_b;
  logic [3:0]  out_a, out_b;

  hdmi_frame_addr_gen_if #(.ADDR_W(32)) ifa ();
  hdmi_frame_addr_gen_if #(.ADDR_W(32)) ifb ();

  assign ifa.cmd_ready = rdy_a;
  assign ifa.cmd_done  = auto_a ? acc_a2 : done_a;
  assign ifb.cmd_ready = rdy_b;
  assign ifb.cmd_done  = auto_b ? acc_b2 : done_b;

  hdmi_frame_addr_gen dut_a (
    .clk_vga(clk_vga), .rst(rst), .frame_start(fs_a), .line_start(ls_a), .fb_base(fb_a),
    .cmd(ifa), .active(active_a), .frame_done(fd_a), .line_overrun(ovr_a), .outstanding(out_a)
  );

  hdmi_frame_addr_gen #(
    .X_SIZE(100), .Y_SIZE(2), .BURST_WORDS(64), .BYTES_PER_PIXEL(4),
    .LINE_STRIDE(1024), .MAX_OUTSTANDING(2), .ADDR_W(32)
  ) dut_b (
    .clk_vga(clk_vga), .rst(rst), .frame_start(fs_b), .line_start(ls_b), .fb_base(fb_b),
    .cmd(ifb), .active(active_b), .frame_done(fd_b), .line_overrun(ovr_b), .outstanding(out_b)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0, errors = 0;
  int   acc_cnt_a = 0, acc_cnt_b = 0, fdc_a = 0, fdc_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic push(input bit which, input logic [31:0] addr, input logic [15:0] len);
    exp_t e;
    e.addr = addr;
    e.len  = len;
    if (which) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  // Read engine model: completion two cycles after each accept
  always @(posedge clk_vga) begin
    acc_a1 <= ifa.cmd_valid && rdy_a && !rst;
    acc_a2 <= acc_a1;
    acc_b1 <= ifb.cmd_valid && rdy_b && !rst;
    acc_b2 <= acc_b1;
  end

  // Monitors: every accepted command pops one expectation
  always @(negedge clk_vga) begin
    if (!rst && ifa.cmd_valid && rdy_a) begin
      acc_cnt_a++;
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_a unexpected: got addr %h len %0d, required no command", ifa.cmd_addr, ifa.cmd_len);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("cmd_a", {16'h0, ifa.cmd_addr, ifa.cmd_len}, {16'h0, e.addr, e.len});
      end
    end
    if (fd_a) fdc_a++;
  end

  always @(negedge clk_vga) begin
    if (!rst && ifb.cmd_valid && rdy_b) begin
      acc_cnt_b++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_b unexpected: got addr %h len %0d, required no command", ifb.cmd_addr, ifb.cmd_len);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("cmd_b", {16'h0, ifb.cmd_addr, ifb.cmd_len}, {16'h0, e.addr, e.len});
      end
    end
    if (fd_b) fdc_b++;
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", 64'(ifa.cmd_valid), 64'd0);
    check("rst_addr", 64'(ifa.cmd_addr), 64'd0);
    check("rst_len", 64'(ifa.cmd_len), 64'd0);
    check("rst_flags", {61'd0, active_a, fd_a, ovr_a}, 64'd0);
    check("rst_outstanding", 64'(out_a), 64'd0);
    rst = 1'b0;
    tick();

    // Full default frame: 256 lines of 4 x 64-pixel bursts
    fb_a = 32'h1000_0000; rdy_a = 1'b1; auto_a = 1'b1;
    fs_a = 1'b1; tick(); fs_a = 1'b0;
    check("t1_active", 64'(active_a), 64'd1);
    for (int l = 0; l < 256; l++) begin
      for (int k = 0; k < 4; k++) push(1'b0, 32'h1000_0000 + 32'(l) * 32'h400 + 32'(k) * 32'h100, 16'd64);
      ls_a = 1'b1; tick(); ls_a = 1'b0;
      repeat (9) tick();
    end
    repeat (5) tick();
    check("t1_cmd_count", 64'(acc_cnt_a), 64'd1024);
    check("t1_frame_done", 64'(fdc_a), 64'd1);
    check("t1_active_end", 64'(active_a), 64'd0);
    check("t1_outstanding", 64'(out_a), 64'd0);

    // Partial final burst: 100-pixel lines, 2 lines
    fb_b = 32'h0000_8000; rdy_b = 1'b1; auto_b = 1'b1;
    fs_b = 1'b1; tick(); fs_b = 1'b0;
    for (int l = 0; l < 2; l++) begin
      push(1'b1, 32'h0000_8000 + 32'(l) * 32'h400, 16'd64);
      push(1'b1, 32'h0000_8100 + 32'(l) * 32'h400, 16'd36);
      ls_b = 1'b1; tick(); ls_b = 1'b0;
      repeat (9) tick();
    end
    repeat (5) tick();
    check("t2_cmd_count", 64'(acc_cnt_b), 64'd4);
    check("t2_frame_done", 64'(fdc_b), 64'd1);
    check("t2_active_end", 64'(active_b), 64'd0);

    // Outstanding limit of 2 with completions withheld
    auto_b = 1'b0; fb_b = 32'h0000_9000;
    fs_b = 1'b1; tick(); fs_b = 1'b0;
    push(1'b1, 32'h0000_9000, 16'd64);
    push(1'b1, 32'h0000_9100, 16'd36);
    ls_b = 1'b1; tick(); ls_b = 1'b0;
    repeat (5) tick();
    check("t4_out_two", 64'(out_b), 64'd2);
    push(1'b1, 32'h0000_9400, 16'd64);
    push(1'b1, 32'h0000_9500, 16'd36);
    ls_b = 1'b1; tick(); ls_b = 1'b0;
    repeat (3) tick();
    check("t4_blocked_valid", 64'(ifb.cmd_valid), 64'd0);
    check("t4_blocked_out", 64'(out_b), 64'd2);
    check("t4_blocked_count", 64'(acc_cnt_b), 64'd6);
    done_b = 1'b1; tick(); done_b = 1'b0;
    check("t4_release_valid", 64'(ifb.cmd_valid), 64'd1);
    tick();
    check("t4_third_count", 64'(acc_cnt_b), 64'd7);
    check("t4_third_out", 64'(out_b), 64'd2);
    check("t4_third_valid", 64'(ifb.cmd_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      done_b = 1'b1; tick(); done_b = 1'b0; tick();
    end
    check("t4_final_count", 64'(acc_cnt_b), 64'd8);
    check("t4_final_out", 64'(out_b), 64'd0);
    check("t4_frame_done", 64'(fdc_b), 64'd2);

    // Back-pressure: command held stable for 5 cycles
    fb_a = 32'h3000_0000; rdy_a = 1'b0; auto_a = 1'b1;
    fs_a = 1'b1; tick(); fs_a = 1'b0;
    for (int k = 0; k < 4; k++) push(1'b0, 32'h3000_0000 + 32'(k) * 32'h100, 16'd64);
    ls_a = 1'b1; tick(); ls_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(ifa.cmd_valid), 64'd1);
      check("t3_hold_addr", 64'(ifa.cmd_addr), 64'h3000_0000);
      check("t3_hold_len", 64'(ifa.cmd_len), 64'd64);
      tick();
    end
    check("t3_none_accepted", 64'(acc_cnt_a), 64'd1024);
    rdy_a = 1'b1;
    repeat (8) tick();
    check("t3_line_count", 64'(acc_cnt_a), 64'd1028);

    // Overrun: second line_start while issuing
    rdy_a = 1'b0;
    for (int k = 0; k < 4; k++) push(1'b0, 32'h3000_0400 + 32'(k) * 32'h100, 16'd64);
    ls_a = 1'b1; tick(); ls_a = 1'b0;
    ls_a = 1'b1; tick(); ls_a = 1'b0;
    check("t5_overrun_set", 64'(ovr_a), 64'd1);
    rdy_a = 1'b1;
    repeat (8) tick();
    check("t5_overrun_held", 64'(ovr_a), 64'd1);
    check("t5_line_count", 64'(acc_cnt_a), 64'd1032);
    fb_a = 32'h4000_0000;
    fs_a = 1'b1; tick(); fs_a = 1'b0;
    check("t5_overrun_clear", 64'(ovr_a), 64'd0);
    check("t5_active", 64'(active_a), 64'd1);

    // Resync with a command pending: finish it, then restart at the new base
    rdy_a = 1'b0;
    push(1'b0, 32'h4000_0000, 16'd64);
    ls_a = 1'b1; tick(); ls_a = 1'b0;
    check("t6_pending_valid", 64'(ifa.cmd_valid), 64'd1);
    fb_a = 32'h2000_0000;
    fs_a = 1'b1; tick(); fs_a = 1'b0;
    fb_a = 32'h5000_0000;
    check("t6_still_pending", 64'(ifa.cmd_addr), 64'h4000_0000);
    rdy_a = 1'b1;
    tick();
    check("t6_after_accept_valid", 64'(ifa.cmd_valid), 64'd0);
    repeat (4) tick();
    check("t6_no_frame_done", 64'(fdc_a), 64'd1);
    check("t6_active", 64'(active_a), 64'd1);
    auto_a = 1'b0;
    for (int k = 0; k < 4; k++) push(1'b0, 32'h2000_0000 + 32'(k) * 32'h100, 16'd64);
    ls_a = 1'b1; tick(); ls_a = 1'b0;
    repeat (8) tick();
    check("t6_new_base_count", 64'(acc_cnt_a), 64'd1037);
    check("t6_out_full", 64'(out_a), 64'd4);
    ls_a = 1'b1; tick(); ls_a = 1'b0;
    check("t6_blocked_valid", 64'(ifa.cmd_valid), 64'd0);

    // Reset mid-burst
    rst = 1'b1; tick();
    check("rst2_outstanding", 64'(out_a), 64'd0);
    check("rst2_flags", {61'd0, active_a, fd_a, ovr_a}, 64'd0);
    check("rst2_cmd", {15'd0, ifa.cmd_valid, ifa.cmd_addr, ifa.cmd_len}, 64'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rst2_idle_valid", 64'(ifa.cmd_valid), 64'd0);

    check("queue_a_empty", 64'(qa.size()), 64'd0);
    check("queue_b_empty", 64'(qb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
